// File: rtl/hlsm_pkg.sv
// hlsm_pkg
//   Shared definitions for the HLSM initiator slice: controller state
//   encoding and the default width / watchdog limit used by the
//   initiator, its responder-bus interface and the watchdog counter.
package hlsm_pkg;

  // Controller states of the initiator
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RESULT    = 2'd3
  } hlsm_state_e;

  localparam int HLSM_DEFAULT_W              = 32;
  localparam int HLSM_DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/hlsm_initiator_if.sv
// hlsm_initiator_if
//   Bus between the HLSM initiator and the HLSM responder.
//   Start        : launch pulse, initiator -> responder
//   a/b/c/seven/nine : operands, initiator -> responder (W bits each)
//   Done         : completion flag, responder -> initiator
//   z/x          : results, responder -> initiator (W bits each)
//   Modports: master (initiator side), slave (responder side).
interface hlsm_initiator_if
  import hlsm_pkg::*;
#(
  parameter int W = HLSM_DEFAULT_W
) ();

  logic         Start;
  logic         Done;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] seven;
  logic [W-1:0] nine;
  logic [W-1:0] z;
  logic [W-1:0] x;

  modport master (
    output Start, a, b, c, seven, nine,
    input  Done, z, x
  );

  modport slave (
    input  Start, a, b, c, seven, nine,
    output Done, z, x
  );

endinterface

// File: rtl/hlsm_timeout_ctr.sv
// hlsm_timeout_ctr
//   Watchdog counter for the Done wait. Cleared to zero by 'clear',
//   advances once per cycle while 'enable' is high, and raises
//   'expired' in the LIMIT-th enabled cycle after a clear (count has
//   reached LIMIT-1). The count parks there until the next clear.
//   Ports: Clk, Rst (sync, active-high), clear, enable, expired.
module hlsm_timeout_ctr
  import hlsm_pkg::*;
#(
  parameter int LIMIT = HLSM_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Count cycles spent waiting; saturate at the last value so expiry
  // stays asserted rather than wrapping around.
  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/hlsm_initiator.sv
// hlsm_initiator
//   Accepts one job at a time, launches the HLSM responder with a
//   one-cycle Start pulse, waits for a fresh rising edge of Done,
//   captures z/x and holds them until the consumer takes them.
//   Ports:
//     Clk, Rst                 : clock, synchronous active-high reset
//     job_valid/job_ready      : job handshake
//     job_a..job_nine          : job operands (W bits)
//     bus (master)             : responder bus (Start, operands, Done, z, x)
//     res_valid/res_ready      : result handshake
//     res_z, res_x, res_err    : captured results, timeout flag
//   Build option: define HLSM_TIMEOUT_EN to add a Done watchdog of
//   TIMEOUT_CYCLES cycles; without it res_err is always 0 and the
//   controller waits for Done indefinitely.
module hlsm_initiator
  import hlsm_pkg::*;
#(
  parameter int W              = HLSM_DEFAULT_W,
  parameter int TIMEOUT_CYCLES = HLSM_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [W-1:0]      job_a,
  input  logic [W-1:0]      job_b,
  input  logic [W-1:0]      job_c,
  input  logic [W-1:0]      job_seven,
  input  logic [W-1:0]      job_nine,
  hlsm_initiator_if.master  bus,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_z,
  output logic [W-1:0]      res_x,
  output logic              res_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("hlsm_initiator: TIMEOUT_CYCLES must be at least 1");
  end

  hlsm_state_e  state;
  hlsm_state_e  state_next;

  logic         accept;
  logic         done_q;
  logic         done_rise;
  logic         complete;
  logic         expire;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] op_c;
  logic [W-1:0] op_seven;
  logic [W-1:0] op_nine;

  assign accept    = job_valid && job_ready;
  // Only a fresh edge completes a job: a Done level left high by the
  // previous job must not finish the next one.
  assign done_rise = bus.Done && !done_q;
  assign complete  = (state == WAIT_DONE) && done_rise;

`ifdef HLSM_TIMEOUT_EN
  logic to_expired;

  // Clearing during LAUNCH makes the count start at zero on the first
  // WAIT_DONE cycle.
  hlsm_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (state == LAUNCH),
    .enable  (state == WAIT_DONE),
    .expired (to_expired)
  );

  assign expire = (state == WAIT_DONE) && to_expired;
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. A completion seen in the same
  // cycle as expiry wins because the result path checks it first.
  always_comb begin
    state_next = state;
    job_ready  = 1'b0;
    bus.Start  = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        job_ready = !Rst;
        if (accept) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        bus.Start  = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (complete || expire) begin
          state_next = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands change only on job accept, so they stay put for the whole
  // launch and wait.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      op_seven <= '0;
      op_nine  <= '0;
    end else if (accept) begin
      op_a     <= job_a;
      op_b     <= job_b;
      op_c     <= job_c;
      op_seven <= job_seven;
      op_nine  <= job_nine;
    end
  end

  assign bus.a     = op_a;
  assign bus.b     = op_b;
  assign bus.c     = op_c;
  assign bus.seven = op_seven;
  assign bus.nine  = op_nine;

  // Previous-cycle Done, for edge detection
  always_ff @(posedge Clk) begin
    if (Rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= bus.Done;
    end
  end

  // Result capture: responder values on completion, zeros on expiry
  always_ff @(posedge Clk) begin
    if (Rst) begin
      res_z <= '0;
      res_x <= '0;
    end else if (complete) begin
      res_z <= bus.z;
      res_x <= bus.x;
    end else if (expire) begin
      res_z <= '0;
      res_x <= '0;
    end
  end

`ifdef HLSM_TIMEOUT_EN
  // Error flag marks a result produced by the watchdog
  always_ff @(posedge Clk) begin
    if (Rst) begin
      res_err <= 1'b0;
    end else if (complete) begin
      res_err <= 1'b0;
    end else if (expire) begin
      res_err <= 1'b1;
    end
  end
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_hlsm_initiator.sv
// tb_hlsm_initiator
//   Directed bench for hlsm_initiator with a behavioural HLSM responder
//   (z = a + b - c, x = nine ^ seven ^ z) and a result scoreboard.
//   Define HLSM_TIMEOUT_EN to also exercise the Done watchdog
//   (TIMEOUT_CYCLES = 8).
module tb_hlsm_initiator;
  import hlsm_pkg::*;

  localparam int W = 32;
`ifdef HLSM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  typedef struct packed {
    logic [W-1:0] z;
    logic [W-1:0] x;
    logic         err;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         job_valid;
  logic         job_ready;
  logic [W-1:0] job_a, job_b, job_c, job_seven, job_nine;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_z, res_x;
  logic         res_err;

  logic         respDone;
  logic         manDone;
  logic [W-1:0] respZ, respX;
  bit           respOn   = 1'b1;
  int           respHold = 0;
  int           respLat  = 3;

  exp_t         expQ[$];
  int           nChecks    = 0;
  int           nPass      = 0;
  int           startCount = 0;
  int           startBase;

  hlsm_initiator_if #(.W(W)) bus ();

  assign bus.Done = respDone | manDone;
  assign bus.z    = respZ;
  assign bus.x    = respX;

  hlsm_initiator #(
    .W              (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_a     (job_a),
    .job_b     (job_b),
    .job_c     (job_c),
    .job_seven (job_seven),
    .job_nine  (job_nine),
    .bus       (bus),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_x     (res_x),
    .res_err   (res_err)
  );

  always #5 Clk = ~Clk;

  // Compare one value and keep the counts
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A bounded wait that ran out counts as a failed comparison
  task automatic noteTimeout(input string name);
    nChecks++;
    $display("[TB] FAIL %s: wait budget expired", name);
  endtask

  // Issue one job (called at a negedge); optionally queue its result
  task automatic applyStimulus(input logic [W-1:0] ja, jb, jc, js, jn,
                               input bit push, input logic [W-1:0] ez, ex,
                               input logic eerr);
    int budget;
    budget = 0;
    while (job_ready !== 1'b1 && budget < 300) begin
      @(negedge Clk);
      budget++;
    end
    if (job_ready !== 1'b1) begin
      noteTimeout("job_ready_wait");
      return;
    end
    job_a = ja; job_b = jb; job_c = jc; job_seven = js; job_nine = jn;
    job_valid = 1'b1;
    if (push) expQ.push_back('{z: ez, x: ex, err: eerr});
    @(negedge Clk);
    job_valid = 1'b0;
    checkOutput("start_latency", W'(bus.Start), W'(1));
    checkOutput("job_ready_busy", W'(job_ready), W'(0));
    checkOutput("op_a", bus.a, ja);
    checkOutput("op_b", bus.b, jb);
    checkOutput("op_c", bus.c, jc);
    checkOutput("op_seven", bus.seven, js);
    checkOutput("op_nine", bus.nine, jn);
  endtask

  // Wait until all queued results are consumed and the DUT is idle
  task automatic waitIdle(input string name);
    int budget;
    budget = 0;
    while ((expQ.size() != 0 || job_ready !== 1'b1) && budget < 300) begin
      @(negedge Clk);
      budget++;
    end
    if (expQ.size() != 0 || job_ready !== 1'b1) noteTimeout(name);
  endtask

  // Behavioural responder: on Start keep Done as-is for respHold
  // cycles, drop it, then raise it with fresh results respLat cycles
  // later. Also checks the one-cycle Done-to-res_valid latency.
  initial begin
    respDone = 1'b0;
    respZ    = '0;
    respX    = '0;
    forever begin
      @(negedge Clk);
      if (!respOn) begin
        respDone = 1'b0;
      end else if (bus.Start === 1'b1) begin
        repeat (respHold) @(negedge Clk);
        respDone = 1'b0;
        repeat (respLat) @(negedge Clk);
        respZ    = bus.a + bus.b - bus.c;
        respX    = bus.nine ^ bus.seven ^ respZ;
        respDone = 1'b1;
        checkOutput("valid_before_done", W'(res_valid), W'(0));
        @(negedge Clk);
        checkOutput("done_to_valid", W'(res_valid), W'(1));
      end
    end
  end

  // Scoreboard monitor: every consumed result is checked in order
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (bus.Start === 1'b1) startCount++;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL res_unexpected: got z=0x%0h x=0x%0h, expected no result", res_z, res_x);
        end else begin
          e = expQ.pop_front();
          checkOutput("res_z", res_z, e.z);
          checkOutput("res_x", res_x, e.x);
          checkOutput("res_err", W'(res_err), W'(e.err));
        end
      end
    end
  end

  // Absolute safety net
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] stopped by watchdog");
  end

  initial begin
    Rst = 1'b1; job_valid = 1'b0; res_ready = 1'b1; manDone = 1'b0;
    job_a = '0; job_b = '0; job_c = '0; job_seven = '0; job_nine = '0;

    // Reset values
    repeat (3) @(negedge Clk);
    checkOutput("rst_job_ready", W'(job_ready), W'(0));
    checkOutput("rst_start", W'(bus.Start), W'(0));
    checkOutput("rst_res_valid", W'(res_valid), W'(0));
    checkOutput("rst_res_err", W'(res_err), W'(0));
    checkOutput("rst_res_z", res_z, '0);
    checkOutput("rst_res_x", res_x, '0);
    checkOutput("rst_op_a", bus.a, '0);
    checkOutput("rst_op_nine", bus.nine, '0);
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("post_rst_job_ready", W'(job_ready), W'(1));

    // Done pulse while idle is ignored
    $display("[TB] Done pulse in IDLE");
    manDone = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (i == 1) manDone = 1'b0;
      checkOutput("idle_done_res_valid", W'(res_valid), W'(0));
      checkOutput("idle_done_job_ready", W'(job_ready), W'(1));
      checkOutput("idle_done_start", W'(bus.Start), W'(0));
    end

    // Single job: 5+3-1 = 7, 9^7^7 = 9
    $display("[TB] single job");
    respHold = 0; respLat = 3;
    startBase = startCount;
    applyStimulus(32'd5, 32'd3, 32'd1, 32'd7, 32'd9, 1'b1, 32'd7, 32'd9, 1'b0);
    @(negedge Clk);
    checkOutput("start_one_cycle", W'(bus.Start), W'(0));
    waitIdle("single_job_wait");
    checkOutput("single_start_count", W'(startCount - startBase), W'(1));

    // Back-to-back jobs with Done still high at each launch
    // job1: 10+20-5 = 25, 2^1^25 = 26 ; job2: 100+1-0 = 0x65, 0xF0^0x0F^0x65 = 0x9A
    $display("[TB] back-to-back jobs with held Done");
    respHold = 4; respLat = 2;
    startBase = startCount;
    applyStimulus(32'd10, 32'd20, 32'd5, 32'd1, 32'd2, 1'b1, 32'd25, 32'd26, 1'b0);
    applyStimulus(32'd100, 32'd1, 32'd0, 32'h0F, 32'hF0, 1'b1, 32'h65, 32'h9A, 1'b0);
    waitIdle("b2b_wait");
    checkOutput("b2b_start_count", W'(startCount - startBase), W'(2));

    // Result held while the consumer stalls: 2+2-1 = 3, 4^3^3 = 4
    $display("[TB] result hold under backpressure");
    respHold = 0; respLat = 2;
    res_ready = 1'b0;
    applyStimulus(32'd2, 32'd2, 32'd1, 32'd3, 32'd4, 1'b1, 32'd3, 32'd4, 1'b0);
    begin
      int budget;
      budget = 0;
      while (res_valid !== 1'b1 && budget < 100) begin
        @(negedge Clk);
        budget++;
      end
      if (res_valid !== 1'b1) noteTimeout("hold_valid_wait");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checkOutput("hold_res_valid", W'(res_valid), W'(1));
      checkOutput("hold_res_z", res_z, 32'd3);
      checkOutput("hold_res_x", res_x, 32'd4);
      checkOutput("hold_job_ready", W'(job_ready), W'(0));
    end
    @(posedge Clk);
    #1 res_ready = 1'b1;
    waitIdle("hold_wait");

    // Reset while waiting for Done drops the job
    $display("[TB] reset in WAIT_DONE");
    respOn = 1'b0;
    repeat (2) @(negedge Clk);
    applyStimulus(32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 1'b0, '0, '0, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checkOutput("midrst_start", W'(bus.Start), W'(0));
    checkOutput("midrst_res_valid", W'(res_valid), W'(0));
    checkOutput("midrst_job_ready", W'(job_ready), W'(0));
    checkOutput("midrst_res_z", res_z, '0);
    checkOutput("midrst_op_a", bus.a, '0);
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("midrst_job_ready_after", W'(job_ready), W'(1));
    manDone = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i == 1) manDone = 1'b0;
      checkOutput("late_done_res_valid", W'(res_valid), W'(0));
      checkOutput("late_done_start", W'(bus.Start), W'(0));
      checkOutput("late_done_job_ready", W'(job_ready), W'(1));
    end

`ifdef HLSM_TIMEOUT_EN
    // Done never comes: result after exactly TO waiting cycles
    $display("[TB] watchdog expiry");
    applyStimulus(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 1'b1, '0, '0, 1'b1);
    for (int i = 1; i <= TO; i++) begin
      @(negedge Clk);
      checkOutput("to_not_yet_valid", W'(res_valid), W'(0));
    end
    @(negedge Clk);
    checkOutput("to_valid", W'(res_valid), W'(1));
    waitIdle("timeout_wait");
`else
    // Without the watchdog the wait is unbounded
    $display("[TB] no watchdog: wait persists");
    applyStimulus(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 1'b0, '0, '0, 1'b0);
    begin
      bit sawValid;
      sawValid = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge Clk);
        if (res_valid === 1'b1) sawValid = 1'b1;
      end
      checkOutput("no_to_never_valid", W'(sawValid), W'(0));
    end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("no_to_idle_after_rst", W'(job_ready), W'(1));
`endif

    repeat (3) @(negedge Clk);
    checkOutput("queue_drained", W'(expQ.size()), W'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
